// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: reset PC, NOP encoding, fetch FSM states
// and small PC arithmetic helpers.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    BUF   = 1'b1
  } fetch_state_e;

  // Sequential PC; the 32-bit add wraps naturally at the top of memory.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load enable, synchronous clear to a NOP bubble.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] next_instr,
  input  logic [31:0] next_pc_plus4,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      instr    <= NOP;
      pc_plus4 <= 32'd0;
      valid    <= 1'b0;
    end else if (en) begin
      instr    <= next_instr;
      pc_plus4 <= next_pc_plus4;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, one-entry skid buffer for stalls,
// branch/jump redirect, and the IF/ID register feeding decode.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  skid_instr;
  logic [31:0]  skid_pc_plus4;

  logic         redirect;
  logic [31:0]  redirect_pc;
  logic         ifid_en;
  logic         ifid_clr;
  logic [31:0]  ifid_instr_nxt;
  logic [31:0]  ifid_pc4_nxt;

  assign imem_addr = pc;

  // Branch wins over jump when both are asserted in the same cycle.
  always_comb begin
    redirect    = branch_taken | jump;
    redirect_pc = word_align(branch_taken ? branch_target : jump_target);
  end

  always_comb begin
    ifid_en        = 1'b0;
    ifid_clr       = 1'b0;
    ifid_instr_nxt = imem_rdata;
    ifid_pc4_nxt   = pc_plus4(pc);
    if (redirect) begin
      ifid_clr = 1'b1;
    end else if (state == FETCH) begin
      if (imem_ready && !stall) begin
        ifid_en = 1'b1;
      end else if (!imem_ready && !stall) begin
        ifid_clr = 1'b1;
      end
    end else if (!stall) begin
      ifid_en        = 1'b1;
      ifid_instr_nxt = skid_instr;
      ifid_pc4_nxt   = skid_pc_plus4;
    end
  end

  // A redirect abandons any in-flight word and empties the skid buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FETCH;
      imem_req      <= 1'b1;
      pc            <= RESET_PC;
      skid_instr    <= NOP;
      skid_pc_plus4 <= 32'd0;
    end else if (redirect) begin
      state    <= FETCH;
      imem_req <= 1'b1;
      pc       <= redirect_pc;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            pc <= pc_plus4(pc);
            if (stall) begin
              skid_instr    <= imem_rdata;
              skid_pc_plus4 <= pc_plus4(pc);
              state         <= BUF;
              imem_req      <= 1'b0;
            end
          end
        end
        BUF: begin
          if (!stall) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk           (clk),
    .rst           (rst),
    .en            (ifid_en),
    .clr           (ifid_clr),
    .next_instr    (ifid_instr_nxt),
    .next_pc_plus4 (ifid_pc4_nxt),
    .instr         (if_id_instr),
    .pc_plus4      (if_id_pc_plus4),
    .valid         (if_id_valid)
  );

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, PC loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port stall  input  1  downstream decode cannot accept; hold IF/ID.
REQ-005 SHALL have port branch_taken  input  1  redirect request from decode.
REQ-006 SHALL have port branch_target  input  32  branch redirect address.
REQ-007 SHALL have port jump  input  1  j-type redirect request.
REQ-008 SHALL have port jump_target  input  32  jump redirect address.
REQ-009 SHALL have port imem_req  output  1  fetch request valid.
REQ-010 SHALL have port imem_addr  output  32  fetch address (= pc).
REQ-011 SHALL have port imem_ready  input  1  memory returns word this cycle.
REQ-012 SHALL have port imem_rdata  input  32  instruction word, valid when imem_req && imem_ready.
REQ-013 SHALL have port if_id_instr  output  32  registered instruction to decode.
REQ-014 SHALL have port if_id_pc_plus4  output  32  registered PC+4 of that instruction.
REQ-015 SHALL have port if_id_valid  output  1  IF/ID holds a real instruction.

Function
REQ-016 SHALL implement two states: FETCH (imem_req=1, imem_addr=pc) and BUF (imem_req=0, fetched word held in skid buffer).
REQ-017 FETCH, ready, !stall: SHALL load IF/ID {imem_rdata, pc+4, valid=1}, pc<=pc+4, stay FETCH; one instruction per cycle at full rate.
REQ-018 FETCH, ready, stall: SHALL hold IF/ID, store {imem_rdata, pc+4} in skid buffer, pc<=pc+4, go BUF.
REQ-019 FETCH, !ready, !stall: SHALL clear if_id_valid (bubble), hold pc.
REQ-020 FETCH, !ready, stall: SHALL hold IF/ID and pc unchanged.
REQ-021 BUF, !stall: SHALL move skid buffer into IF/ID with valid=1, return to FETCH; BUF, stall: hold everything.
REQ-022 Redirect (branch_taken or jump) SHALL override stall and state: pc<=target, if_id_valid<=0, skid buffer discarded, state<=FETCH; a word returned in the same cycle SHALL be dropped.
REQ-023 branch_taken and jump both high SHALL select branch_target.
REQ-024 Redirect targets SHALL have bits [1:0] forced to 0.
REQ-025 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-026 Outstanding request SHALL be abandoned on redirect; imem_addr changes the next cycle.
REQ-027 When if_id_valid=0, if_id_instr SHALL be 32'h0000_0000 (NOP).

Reset
REQ-028 rst high at a clock edge SHALL set pc=RESET_PC, state=FETCH, if_id_instr=0, if_id_pc_plus4=0, if_id_valid=0, skid buffer empty; overrides all inputs including mid-BUF and mid-redirect.
REQ-029 First cycle after rst deasserts SHALL present imem_req=1, imem_addr=RESET_PC.

Structure
REQ-030 Shared package mips_pkg SHALL hold RESET_PC default, NOP constant, and fetch state enum.
REQ-031 IF/ID register (enable, clear, data) SHALL be sub-module if_id_reg; remaining logic inline.

Verification
REQ-032 Reset, ready=1 constant, no stall -> IF/ID pc_plus4 sequence 0x3004, 0x3008, 0x300C on consecutive cycles, valid=1.
REQ-033 ready=0 for 2 cycles at pc=0x3008 -> two bubbles (valid=0), pc held, then word at 0x3008 delivered.
REQ-034 stall high 3 cycles while ready=1 -> state BUF, imem_req=0, IF/ID unchanged; stall low -> buffered word delivered next cycle, no loss or duplicate.
REQ-035 branch_taken=1, target 0x3041 during BUF with stall=1 -> pc=0x3040, valid=0, buffer dropped, next fetch addr 0x3040.
REQ-036 jump to 0xFFFF_FFFC, ready=1 -> delivered pc_plus4=0x0000_0000; rst asserted mid-BUF -> all outputs reset values next edge.
